cpu6502_status_reg: RTL and testbench

CPU6502_STATUS_REG -- requirements
Module: cpu6502_status_reg

---
 rtl/cpu6502_status_reg.sv | 91 +++++++++
 tb/tb_cpu6502_status_reg.sv | 133 +++++++++++++
 2 files changed

// File: rtl/cpu6502_status_reg.sv
// cpu6502_status_reg: 6502 processor status register with prioritised flag writes,
// synchronised set-overflow pin and a one-instruction delayed interrupt mask.
module cpu6502_status_reg #(
    parameter int SO_SYNC_STAGES = 2,
    parameter bit CMOS           = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       instrEnd,
    input  logic       aluCarry,
    input  logic       aluZero,
    input  logic       aluNegative,
    input  logic       aluOverflow,
    input  logic [3:0] flagWe,
    input  logic       loadP,
    input  logic [7:0] dataIn,
    input  logic       setFlag,
    input  logic       clrFlag,
    input  logic [2:0] flagSel,
    input  logic       intEntry,
    input  logic       pushBrk,
    input  logic       soN,
    output logic [7:0] pOut,
    output logic [7:0] pushValue,
    output logic       carryFlag,
    output logic       decimalFlag,
    output logic       overflowFlag,
    output logic       irqMask
);
    logic                      n, v, d, i, z, c;
    logic [SO_SYNC_STAGES-1:0] so_sync;
    logic                      so_last, so_pend, so_fall, so_apply;
    logic [7:0]                p_cur, p_nxt;
    logic                      unused_bits;

    assign p_cur        = {n, v, 2'b11, d, i, z, c};
    assign pOut         = p_cur;
    assign pushValue    = {n, v, 1'b1, pushBrk, d, i, z, c};
    assign carryFlag    = c;
    assign decimalFlag  = d;
    assign overflowFlag = v;
    assign so_fall      = so_last & ~so_sync[SO_SYNC_STAGES-1];
    assign so_apply     = so_pend & ce;
    assign unused_bits  = ^p_nxt[5:4];

    always_comb begin
        p_nxt = p_cur;
        if (loadP) begin
            p_nxt = dataIn;
        end else if (intEntry) begin
            p_nxt[2] = 1'b1;
            if (CMOS) p_nxt[3] = 1'b0;
        end else begin
            if (flagWe[0]) p_nxt[0] = aluCarry;
            if (flagWe[1]) p_nxt[1] = aluZero;
            if (flagWe[2]) p_nxt[6] = aluOverflow;
            if (flagWe[3]) p_nxt[7] = aluNegative;
            // bits 4/5 are not real flags; set+clr together holds the flag
            if ((setFlag | clrFlag) && flagSel[2:1] != 2'b10)
                p_nxt[flagSel] = (setFlag & clrFlag) ? p_cur[flagSel] : setFlag;
        end
        if (so_apply) p_nxt[6] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            so_sync <= '1;
            so_last <= 1'b1;
            so_pend <= 1'b0;
        end else begin
            so_sync <= {so_sync[SO_SYNC_STAGES-2:0], soN};
            so_last <= so_sync[SO_SYNC_STAGES-1];
            so_pend <= so_fall | (so_pend & ~ce);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {n, v, d, z, c} <= '0;
            i               <= 1'b1;
            irqMask         <= 1'b1;
        end else if (ce) begin
            {n, v}        <= p_nxt[7:6];
            {d, i, z, c}  <= p_nxt[3:0];
            // mask follows the I value from before this cycle, unless entering an interrupt
            if (intEntry)      irqMask <= 1'b1;
            else if (instrEnd) irqMask <= i;
        end
    end
endmodule

// File: tb/tb_cpu6502_status_reg.sv
// tb_cpu6502_status_reg: table-driven directed checks of the 6502 status register
// plus hand sequences for async reset and the set-overflow synchroniser.
module tb_cpu6502_status_reg;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       ce = 1'b0, instrEnd = 1'b0;
    logic       aluCarry = 1'b0, aluZero = 1'b0, aluNegative = 1'b0, aluOverflow = 1'b0;
    logic [3:0] flagWe = '0;
    logic       loadP = 1'b0;
    logic [7:0] dataIn = '0;
    logic       setFlag = 1'b0, clrFlag = 1'b0;
    logic [2:0] flagSel = '0;
    logic       intEntry = 1'b0, pushBrk = 1'b0, soN = 1'b1;
    logic [7:0] pOut, pushValue;
    logic       carryFlag, decimalFlag, overflowFlag, irqMask;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    cpu6502_status_reg dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .instrEnd(instrEnd),
        .aluCarry(aluCarry), .aluZero(aluZero), .aluNegative(aluNegative), .aluOverflow(aluOverflow),
        .flagWe(flagWe), .loadP(loadP), .dataIn(dataIn), .setFlag(setFlag), .clrFlag(clrFlag),
        .flagSel(flagSel), .intEntry(intEntry), .pushBrk(pushBrk), .soN(soN),
        .pOut(pOut), .pushValue(pushValue), .carryFlag(carryFlag), .decimalFlag(decimalFlag),
        .overflowFlag(overflowFlag), .irqMask(irqMask)
    );

    typedef struct {
        logic       ce, ie;
        logic [3:0] we, alu;
        logic       ld;
        logic [7:0] din;
        logic       sf, cf;
        logic [2:0] sel;
        logic       ent, brk;
        logic [7:0] ep, epush;
        logic       eirq;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        {instrEnd, flagWe, loadP, setFlag, clrFlag, intEntry} = '0;
        {aluNegative, aluOverflow, aluZero, aluCarry} = '0;
    endtask

    initial begin
        // ce ie  we    alu   ld din    sf cf sel ent brk  pOut   push   irq
        vecs = '{
            '{1, 0, 4'h0, 4'h0, 1, 8'hFF, 0, 0, 0, 0, 1, 8'hFF, 8'hFF, 1},
            '{1, 0, 4'hF, 4'hF, 1, 8'h00, 0, 0, 0, 1, 0, 8'h30, 8'h20, 1},
            '{1, 0, 4'hF, 4'hA, 0, 8'h00, 0, 0, 0, 0, 0, 8'hB2, 8'hA2, 1},
            '{1, 0, 4'h1, 4'h1, 0, 8'h00, 0, 0, 0, 0, 0, 8'hB3, 8'hA3, 1},
            '{1, 0, 4'hF, 4'h0, 0, 8'h00, 1, 0, 3, 0, 1, 8'h38, 8'h38, 1},
            '{1, 0, 4'h0, 4'h0, 0, 8'h00, 1, 0, 4, 0, 0, 8'h38, 8'h28, 1},
            '{1, 0, 4'h0, 4'h0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h39, 8'h29, 1},
            '{1, 0, 4'h0, 4'h0, 0, 8'h00, 1, 1, 0, 0, 0, 8'h39, 8'h29, 1},
            '{1, 0, 4'h0, 4'h0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h38, 8'h28, 1},
            '{0, 0, 4'h0, 4'h0, 1, 8'hFF, 0, 0, 0, 0, 0, 8'h38, 8'h28, 1},
            '{1, 0, 4'hF, 4'hF, 0, 8'h00, 0, 0, 0, 1, 0, 8'h3C, 8'h2C, 1},
            '{1, 0, 4'h0, 4'h0, 1, 8'hC3, 0, 0, 0, 0, 1, 8'hF3, 8'hF3, 1},
            '{1, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hF3, 8'hE3, 1},
            '{1, 1, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hF3, 8'hE3, 0},
            '{1, 1, 4'h0, 4'h0, 0, 8'h00, 1, 0, 2, 0, 0, 8'hF7, 8'hE7, 0},
            '{1, 1, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hF7, 8'hE7, 1},
            '{1, 1, 4'h0, 4'h0, 0, 8'h00, 0, 1, 2, 0, 0, 8'hF3, 8'hE3, 1},
            '{1, 1, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0, 0, 0, 8'hF3, 8'hE3, 0},
            '{1, 0, 4'h0, 4'h0, 0, 8'h00, 0, 0, 0, 1, 0, 8'hF7, 8'hE7, 1}
        };
        #12;
        check("reset_p", pOut, 8'h34);
        check("reset_irq", {7'd0, irqMask}, 8'h01);
        rst_n = 1'b1;
        tick();
        foreach (vecs[k]) begin
            ce = vecs[k].ce; instrEnd = vecs[k].ie; flagWe = vecs[k].we;
            {aluNegative, aluOverflow, aluZero, aluCarry} = vecs[k].alu;
            loadP = vecs[k].ld; dataIn = vecs[k].din; setFlag = vecs[k].sf; clrFlag = vecs[k].cf;
            flagSel = vecs[k].sel; intEntry = vecs[k].ent; pushBrk = vecs[k].brk;
            tick();
            check($sformatf("vec%0d_p", k), pOut, vecs[k].ep);
            check($sformatf("vec%0d_push", k), pushValue, vecs[k].epush);
            check($sformatf("vec%0d_irq", k), {7'd0, irqMask}, {7'd0, vecs[k].eirq});
            check($sformatf("vec%0d_cdv", k), {5'd0, carryFlag, decimalFlag, overflowFlag},
                  {5'd0, vecs[k].ep[0], vecs[k].ep[3], vecs[k].ep[6]});
        end
        // async reset with P=FF and mask cleared
        idle(); ce = 1'b1; loadP = 1'b1; dataIn = 8'h00; tick();
        idle(); instrEnd = 1'b1; tick();
        idle(); loadP = 1'b1; dataIn = 8'hFF; tick();
        idle();
        check("pre_reset_p", pOut, 8'hFF);
        check("pre_reset_irq", {7'd0, irqMask}, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_p", pOut, 8'h34);
        check("async_reset_irq", {7'd0, irqMask}, 8'h01);
        #2 rst_n = 1'b1;
        tick();
        // set-overflow beats a same-cycle ALU clear of V
        flagWe = 4'b0100; aluOverflow = 1'b0; soN = 1'b0;
        tick(); check("so_edge1_v", {7'd0, overflowFlag}, 8'h00);
        tick(); check("so_edge2_v", {7'd0, overflowFlag}, 8'h00);
        tick(); tick();
        check("so_applied_v", {7'd0, overflowFlag}, 8'h01);
        check("so_applied_p", pOut, 8'h74);
        idle(); soN = 1'b1;
        tick(); tick(); tick();
        clrFlag = 1'b1; flagSel = 3'd6; tick(); idle();
        check("clv_p", pOut, 8'h34);
        // edge seen with ce=0 waits for the next enabled cycle
        ce = 1'b0; soN = 1'b0;
        repeat (6) tick();
        check("so_hold_v", {7'd0, overflowFlag}, 8'h00);
        ce = 1'b1; tick();
        check("so_release_v", {7'd0, overflowFlag}, 8'h01);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
